io_select_sequencer: RTL and testbench
======================================

// Module: io_select_sequencer
// PURPOSE
//  Consumes the active-low wide-AND decode (DECODEL) from the address-match NAND macro and turns it into a timed I/O cycle.
//  Outputs: chip select, gated read/write strobes and a READY handshake back to the bus master.
//  Sits directly downstream of the decode NAND; one instance per decoded peripheral window.
// PARAMETERS
//  WAIT_W    3  width of wait-state count and WAITCFG port
//  DEF_WAIT  2  wait states loaded at reset (must be < 2**WAIT_W)
//  HOLD_CYC  1  cycles CSL stays low after strobe release (1..3)
// PORTS
//  CLK      in   1       single system clock; all state on rising edge
//  RESET    in   1       synchronous, active-high reset
//  DECODEL  in   1       active-low address match from decode NAND (combinational, unregistered)
//  RDL      in   1       active-low bus read request
//  WRL      in   1       active-low bus write request
//  WAITCFG  in   WAIT_W  new wait-state count
//  CFG_LD   in   1       load WAITCFG into wait register this cycle
//  CSL      out  1       active-low chip select to peripheral
//  IORDL    out  1       active-low peripheral read strobe
//  IOWRL    out  1       active-low peripheral write strobe
//  READY    out  1       high for exactly one cycle when access completes
//  BUSY     out  1       high whenever FSM not in IDLE
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values: CSL=1, IORDL=1, IOWRL=1, READY=0, BUSY=0, state=IDLE, waitreg=DEF_WAIT, counters=0.
//  All outputs registered; no combinational input-to-output path.
//  Request = DECODEL==0 && (RDL==0 || WRL==0), sampled each cycle.
//  If RDL and WRL are both low, read wins; dir latched on entry to SETUP.
//  FSM transitions:
//    IDLE    -> SETUP on request; CSL goes low next cycle.
//    SETUP   1 cycle; strobe of latched dir asserted on exit; cnt <= waitreg.
//    ACTIVE  decrement cnt each cycle; when cnt==0: READY=1 for one cycle, strobe released, go to HOLD.
//            waitreg=0 -> strobe low exactly one cycle.
//    HOLD    CSL low HOLD_CYC cycles, then CSL=1 -> RECOVER.
//    RECOVER wait until RDL==1 && WRL==1, then IDLE. Blocks re-trigger from a held request.
//  Latency: request seen in cycle N -> CSL low N+1 -> strobe low N+2 -> READY at N+2+waitreg.
//  Abort: DECODEL rising or latched strobe input rising during SETUP/ACTIVE ->
//    release strobe next cycle, no READY, go to HOLD.
//  CFG_LD: applies to waitreg at any time; an in-flight count is not altered; takes effect on next access.
//  RESET mid-access: all outputs return to reset values on the next edge; no READY is issued.
//  Counter: down-counts only, never wraps; DEF_WAIT >= 2**WAIT_W is a compile-time error.
// CONFIGURATION
//  IOSEL_DEGLITCH_EN defined:
//    DECODEL must be low for 2 consecutive samples before a request is recognised.
//    Adds 1 cycle to every latency above.
//    Abort requires DECODEL high for 2 consecutive samples.
//  Undefined: single-sample recognition and abort as described above.
// STRUCTURE
//  Package iosel_pkg: enum iosel_state_t {IDLE,SETUP,ACTIVE,HOLD,RECOVER}; typedef dir_t {DIR_RD,DIR_WR}; localparam HOLD_MAX=3.
//  One sub-module iosel_wait_counter: loadable down-counter, WAIT_W wide, outputs zero flag.
//  FSM, strobe registers and deglitch stay in the top level.
// TESTING
//  1 Read, waitreg=2: DECODEL=0, RDL=0 at N -> CSL=0 @N+1, IORDL=0 @N+2..N+4, READY=1 @N+4 only, CSL=1 @N+5.
//  2 Write, CFG_LD with WAITCFG=0 beforehand -> IOWRL low one cycle, READY same cycle; IORDL stays 1.
//  3 RDL and WRL both low -> read cycle only; RDL held low after READY -> FSM stays RECOVER, no second access.
//  4 DECODEL goes high mid-ACTIVE with waitreg=5 -> strobe released next cycle, READY never pulses, back to IDLE.
//  5 RESET asserted during ACTIVE -> next edge: all outputs at reset values; waitreg=DEF_WAIT.
//  6 With IOSEL_DEGLITCH_EN: single-cycle DECODEL=0 pulse -> CSL stays 1; two-cycle low -> access with +1 latency.

Source files
------------

// File: rtl/iosel_pkg.sv
// ============================================================================
// Module : iosel_pkg
// Brief  : Shared types and constants for the I/O select sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iosel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACTIVE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } iosel_state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam int HOLD_MAX = 3;

endpackage

`default_nettype wire

// File: rtl/iosel_wait_counter.sv
// ============================================================================
// Module : iosel_wait_counter
// Brief  : Loadable down-counter for wait states; saturates at zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iosel_wait_counter #(
  parameter int WAIT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic [WAIT_W-1:0] ld_val_i,
  input  logic              dec_i,
  output logic [WAIT_W-1:0] cnt_o,
  output logic              zero_o
);

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/io_select_sequencer.sv
// ============================================================================
// Module : io_select_sequencer
// Brief  : Turns an active-low address decode into a timed chip-select /
//          strobe / READY cycle. Optional macro IOSEL_DEGLITCH_EN requires two
//          consecutive DECODEL samples for both request and abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_select_sequencer
  import iosel_pkg::*;
#(
  parameter int WAIT_W   = 3,
  parameter int DEF_WAIT = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DECODEL,
  input  logic              RDL,
  input  logic              WRL,
  input  logic [WAIT_W-1:0] WAITCFG,
  input  logic              CFG_LD,
  output logic              CSL,
  output logic              IORDL,
  output logic              IOWRL,
  output logic              READY,
  output logic              BUSY
);

  generate
    if (DEF_WAIT >= (1 << WAIT_W)) begin : g_bad_def_wait
      $error("DEF_WAIT must be below 2**WAIT_W");
    end
    if ((HOLD_CYC < 1) || (HOLD_CYC > HOLD_MAX)) begin : g_bad_hold_cyc
      $error("HOLD_CYC must be within 1..HOLD_MAX");
    end
  endgenerate

  // The hold window counts the final strobe cycle, so CSL rises in the last HOLD cycle.
  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYC - 1);

  iosel_state_t      state_q, state_d;
  dir_t              dir_q;
  logic [WAIT_W-1:0] waitreg_q;
  logic [1:0]        hcnt_q, hcnt_d;
  logic              csl_q, csl_d;
  logic              iordl_q, iordl_d;
  logic              iowrl_q, iowrl_d;
  logic              ready_q, ready_d;
  logic              busy_q;

  logic              dec_match;
  logic              dec_lost;
  logic              req;
  logic              strobe_lost;
  logic              abort;
  logic [WAIT_W-1:0] cnt;
  logic              cnt_zero;

`ifdef IOSEL_DEGLITCH_EN
  logic decl_prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      decl_prev_q <= 1'b1;
    end else begin
      decl_prev_q <= DECODEL;
    end
  end

  assign dec_match = !DECODEL && !decl_prev_q;
  assign dec_lost  = DECODEL && decl_prev_q;
`else
  assign dec_match = !DECODEL;
  assign dec_lost  = DECODEL;
`endif

  assign req         = dec_match && (!RDL || !WRL);
  assign strobe_lost = (dir_q == DIR_RD) ? RDL : WRL;
  assign abort       = dec_lost || strobe_lost;

  iosel_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_counter (
    .clk      (CLK),
    .rst      (RESET),
    .ld_i     (state_q == SETUP),
    .ld_val_i (waitreg_q),
    .dec_i    (state_q == ACTIVE),
    .cnt_o    (cnt),
    .zero_o   (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    csl_d   = csl_q;
    iordl_d = iordl_q;
    iowrl_d = iowrl_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          csl_d   = 1'b0;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = HOLD;
          hcnt_d  = 2'd0;
          csl_d   = (HOLD_LAST == 2'd0);
        end else begin
          state_d = ACTIVE;
          iordl_d = (dir_q != DIR_RD);
          iowrl_d = (dir_q != DIR_WR);
          ready_d = (waitreg_q == '0);
        end
      end
      ACTIVE: begin
        if (abort || cnt_zero) begin
          state_d = HOLD;
          hcnt_d  = 2'd0;
          iordl_d = 1'b1;
          iowrl_d = 1'b1;
          csl_d   = (HOLD_LAST == 2'd0);
        end else begin
          // READY is registered, so it is raised one cycle before the count hits zero.
          ready_d = (cnt == WAIT_W'(1));
        end
      end
      HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          state_d = RECOVER;
          csl_d   = 1'b1;
        end else begin
          hcnt_d  = hcnt_q + 2'd1;
          csl_d   = ((hcnt_q + 2'd1) == HOLD_LAST);
        end
      end
      RECOVER: begin
        if (RDL && WRL) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      dir_q     <= DIR_RD;
      waitreg_q <= WAIT_W'(DEF_WAIT);
      hcnt_q    <= 2'd0;
      csl_q     <= 1'b1;
      iordl_q   <= 1'b1;
      iowrl_q   <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      csl_q   <= csl_d;
      iordl_q <= iordl_d;
      iowrl_q <= iowrl_d;
      ready_q <= ready_d;
      busy_q  <= (state_d != IDLE);
      if (CFG_LD) begin
        waitreg_q <= WAITCFG;
      end
      if ((state_q == IDLE) && req) begin
        dir_q <= RDL ? DIR_WR : DIR_RD;
      end
    end
  end

  assign CSL   = csl_q;
  assign IORDL = iordl_q;
  assign IOWRL = iowrl_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_io_select_sequencer.sv
// ============================================================================
// Module : tb_io_select_sequencer
// Brief  : Directed, table-driven bench for io_select_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_select_sequencer;

`ifdef IOSEL_DEGLITCH_EN
  localparam bit DEGL = 1'b1;
`else
  localparam bit DEGL = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, DECODEL, RDL, WRL, CFG_LD;
  logic [2:0] WAITCFG;
  logic       CSL, IORDL, IOWRL, READY, BUSY;
  logic [4:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  io_select_sequencer #(
    .WAIT_W   (3),
    .DEF_WAIT (2),
    .HOLD_CYC (1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .DECODEL (DECODEL),
    .RDL     (RDL),
    .WRL     (WRL),
    .WAITCFG (WAITCFG),
    .CFG_LD  (CFG_LD),
    .CSL     (CSL),
    .IORDL   (IORDL),
    .IOWRL   (IOWRL),
    .READY   (READY),
    .BUSY    (BUSY)
  );

  // Output vector order: {CSL, IORDL, IOWRL, READY, BUSY}
  assign outs = {CSL, IORDL, IOWRL, READY, BUSY};

  typedef struct {
    string      name;
    logic       rst, dec, rd, wr, ld;
    logic [2:0] cfg;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(string n, logic rst, logic dec, logic rd, logic wr,
                              logic ld, logic [2:0] cfg, logic [4:0] exp);
    vec_t v;
    v.name = n; v.rst = rst; v.dec = dec; v.rd = rd; v.wr = wr;
    v.ld = ld; v.cfg = cfg; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic dec, input logic rd, input logic wr,
                       input logic ld, input logic [2:0] cfg);
    RESET = rst; DECODEL = dec; RDL = rd; WRL = wr; CFG_LD = ld; WAITCFG = cfg;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {CSL,IORDL,IOWRL,READY,BUSY}=%b expected %b", name, outs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Bounded wait for BUSY to drop, tracking any READY pulse on the way.
  task automatic drain(input string name, output logic ready_seen);
    ready_seen = 1'b0;
    for (int k = 0; k < 10 && BUSY; k++) begin
      tick();
      if (READY) ready_seen = 1'b1;
    end
    chk1(name, BUSY, 1'b0);
  endtask

  initial begin
    logic rs;
    drive(1, 1, 1, 1, 0, 3'd0);

    tbl[0]  = mk("reset",           1, 1, 1, 1, 0, 3'd0, 5'b11100);
    tbl[1]  = mk("idle",            0, 1, 1, 1, 0, 3'd0, 5'b11100);
    tbl[2]  = mk("rd_setup",        0, 0, 0, 1, 0, 3'd0, 5'b01101);
    tbl[3]  = mk("rd_strobe1",      0, 0, 0, 1, 0, 3'd0, 5'b00101);
    tbl[4]  = mk("rd_strobe2",      0, 0, 0, 1, 0, 3'd0, 5'b00101);
    tbl[5]  = mk("rd_ready",        0, 0, 0, 1, 0, 3'd0, 5'b00111);
    tbl[6]  = mk("rd_hold",         0, 1, 1, 1, 0, 3'd0, 5'b11101);
    tbl[7]  = mk("rd_recover",      0, 1, 1, 1, 0, 3'd0, 5'b11101);
    tbl[8]  = mk("rd_idle",         0, 1, 1, 1, 0, 3'd0, 5'b11100);
    tbl[9]  = mk("cfg_ld_zero",     0, 1, 1, 1, 1, 3'd0, 5'b11100);
    tbl[10] = mk("wr_setup",        0, 0, 1, 0, 0, 3'd0, 5'b01101);
    tbl[11] = mk("wr_strobe_ready", 0, 0, 1, 0, 0, 3'd0, 5'b01011);
    tbl[12] = mk("wr_hold",         0, 1, 1, 1, 0, 3'd0, 5'b11101);
    tbl[13] = mk("wr_recover",      0, 1, 1, 1, 0, 3'd0, 5'b11101);
    tbl[14] = mk("wr_idle",         0, 1, 1, 1, 0, 3'd0, 5'b11100);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].dec, tbl[i].rd, tbl[i].wr, tbl[i].ld, tbl[i].cfg);
      tick();
      chk(tbl[i].name, tbl[i].exp);
    end

    // Both strobes requested: read wins; a held request must not re-trigger.
    drive(0, 1, 1, 1, 1, 3'd1); tick(); chk("t3_cfg1", 5'b11100);
    drive(0, 0, 0, 0, 0, 3'd0); tick(); chk("t3_setup", 5'b01101);
    tick(); chk("t3_read_only", 5'b00101);
    tick(); chk("t3_ready", 5'b00111);
    tick(); chk("t3_hold", 5'b11101);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("t3_recover_held", 5'b11101);
    end
    drive(0, 1, 1, 1, 0, 3'd0); tick(); chk("t3_idle", 5'b11100);

    // Abort by DECODEL rising mid-ACTIVE with a long wait count.
    drive(0, 1, 1, 1, 1, 3'd5); tick(); chk("t4_cfg5", 5'b11100);
    drive(0, 0, 0, 1, 0, 3'd0); tick(); chk("t4_setup", 5'b01101);
    tick(); chk("t4_active1", 5'b00101);
    tick(); chk("t4_active2", 5'b00101);
    drive(0, 1, 1, 1, 0, 3'd0); tick(); chk("t4_abort_release", 5'b11101);
    drain("t4_back_idle", rs);
    chk1("t4_no_ready", rs, 1'b0);

    // Reset during ACTIVE, then confirm the wait register is back at default.
    drive(0, 0, 0, 1, 0, 3'd0); tick(); chk("t5_setup", 5'b01101);
    tick(); chk("t5_active", 5'b00101);
    drive(1, 1, 1, 1, 0, 3'd0); tick(); chk("t5_reset_mid", 5'b11100);
    drive(0, 0, 0, 1, 0, 3'd0); tick(); chk("t5_setup2", 5'b01101);
    tick(); chk("t5_active_cnt2", 5'b00101);
    // Reload mid-access: the running count must be unaffected.
    drive(0, 0, 0, 1, 1, 3'd0); tick(); chk("t5_inflight_kept", 5'b00101);
    drive(0, 0, 0, 1, 0, 3'd0); tick(); chk("t5_ready_defwait", 5'b00111);
    drive(0, 1, 1, 1, 0, 3'd0); tick(); chk("t5_hold", 5'b11101);
    drain("t5_idle", rs);
    drive(0, 0, 0, 1, 0, 3'd0); tick(); chk("t5_next_setup", 5'b01101);
    tick(); chk("t5_next_uses_cfg0", 5'b00111);
    drive(0, 1, 1, 1, 0, 3'd0); tick(); chk("t5_next_hold", 5'b11101);
    drain("t5_next_idle", rs);

    // Single-cycle DECODEL pulse, then a two-cycle request.
    drive(0, 0, 0, 1, 0, 3'd0); tick();
    chk("t6_pulse_edge1", DEGL ? 5'b11100 : 5'b01101);
    drive(0, 1, 1, 1, 0, 3'd0); tick();
    chk("t6_pulse_edge2", DEGL ? 5'b11100 : 5'b11101);
    drain("t6_pulse_idle", rs);
    chk1("t6_pulse_no_ready", rs, 1'b0);
    drive(0, 0, 0, 1, 0, 3'd0); tick();
    chk("t6_req_edge1", DEGL ? 5'b11100 : 5'b01101);
    tick();
    chk("t6_req_edge2", DEGL ? 5'b01101 : 5'b00111);
    tick();
    chk("t6_req_edge3", DEGL ? 5'b00111 : 5'b11101);
    drive(0, 1, 1, 1, 0, 3'd0);
    drain("t6_req_idle", rs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
